// File: rtl/crypto_pkg.sv
// Shared crypto definitions: FSM states, LFSR step, zero-key seed.
// Used by both the stream encryptor and decryptor.
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [7:0] ZERO_SEED_DEF = 8'hA5;

  // Maximal-length taps 8,6,5,4; a nonzero state never reaches zero.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit keystream LFSR with synchronous load and step.
// Load has priority over step.
module lfsr8
  import crypto_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr8_next(q);
    end
  end

endmodule

// File: rtl/stream_decryptor.sv
// Frame-based stream decryptor: LFSR keystream seeded from the
// register file key, chained with the previous cipher byte.
module stream_decryptor
  import crypto_pkg::*;
#(
  parameter logic [2:0] KEY_ADDR  = 3'd5,
  parameter int         FRAME_LEN = 4,
  parameter logic [7:0] ZERO_SEED = ZERO_SEED_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] rf_a1,
  input  logic [7:0] rf_rd1,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ks;
  logic [7:0] prev_c;
  logic [7:0] seed;
  logic       accept;
  logic       last;
  logic       load;

  assign rf_a1    = KEY_ADDR;
  assign busy     = (state != IDLE);
  assign load     = (state == LOAD);
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (byte_cnt == 8'(FRAME_LEN - 1));
  assign seed     = (rf_rd1 == 8'h00) ? ZERO_SEED : rf_rd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (accept),
    .seed  (seed),
    .q     (ks)
  );

  // Single output register; a new accept overwrites it while draining.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      prev_c    <= '0;
      byte_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        prev_c   <= '0;
        byte_cnt <= '0;
      end
      if (accept) begin
        out_data  <= in_data ^ ks ^ prev_c;
        out_valid <= 1'b1;
        prev_c    <= in_data;
        byte_cnt  <= byte_cnt + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
